fp_round_pack: RTL and testbench
================================

// Module: fp_round_pack
// PURPOSE
// - Pipelined stage directly after the normalizer in the FP add/sub datapath.
// - Takes the normalized 27-bit significand (hidden|frac23|G|R|S) and the exponent/shift pair.
// - Applies the RISC-V rounding mode and packs an IEEE-754 single.
// - Produces fflags. 2-stage pipeline with valid/ready flow control on both sides.
// PARAMETERS
// - EXP_W   8   exponent width (fixed for binary32; other values unsupported)
// - FRAC_W  23  stored fraction width; significand in = FRAC_W+4 = 27 bits
// PORTS
// - clk         in   1   clock, all state on rising edge
// - reset_n     in   1   asynchronous active-low reset
// - in_valid    in   1   input beat valid
// - in_ready    out  1   stage can accept input this cycle
// - in_sign     in   1   result sign
// - in_exp      in   8   biased exponent before normalization
// - in_shift    in   8   two's-complement exponent adjust from normalizer
// - in_sig      in   27  [26]=hidden, [25:3]=frac, [2]=G, [1]=R, [0]=S
// - in_nan      in   1   upstream result is NaN (bypass rounding)
// - in_inf      in   1   upstream result is infinity (bypass rounding)
// - in_nv       in   1   invalid-op flag from upstream, passed to out_flags[4]
// - in_rm       in   3   rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others treated as RNE
// - out_valid   out  1   result valid
// - out_ready   in   1   downstream accepts result
// - out_result  out  32  packed {sign, exp8, frac23}
// - out_flags   out  5   {NV, DZ, OF, UF, NX}; DZ is always 0
// BEHAVIOUR
// - Reset (async, reset_n=0): both stage valids, out_valid, out_result and out_flags = 0.
//   In-flight beats are discarded. in_ready = 1 one cycle after reset release.
// - Handshake: transfer on valid&&ready at either port.
//   - out_valid&&!out_ready holds out_result/out_flags stable.
//   - in_ready = !s1_valid || !s2_valid || out_ready. No combinational path from in_valid to out_valid.
//   - Latency 2 cycles; throughput 1 beat/cycle when out_ready=1. Order preserved.
// - S1 (register on accept):
//   - e = in_exp + sext(in_shift), computed 10-bit signed.
//   - lsb = sig[3], g = sig[2], st = sig[1]|sig[0], inexact = g|st.
//   - inc: RNE g&(st|lsb); RTZ 0; RDN inexact&sign; RUP inexact&~sign; RMM g.
// - S2:
//   - m = {1'b0, sig[26:3]} + inc (25 bits).
//   - If m[24]: exponent e+1, frac = m[23:1] (= 0).
//   - Else if e==0 && m[23]: exponent 1 (subnormal rounded up to normal).
//   - Else: exponent e, frac = m[22:0].
// - Overflow (final exp >= 255): OF=NX=1.
//   - Result is inf if RNE/RMM, or RUP with +, or RDN with -.
//   - Otherwise result is max finite 0x7F7FFFFF | sign<<31.
// - UF = (final exp == 0) && inexact (tininess after rounding). NX = inexact | OF.
// - Priority: in_nan -> 0x7FC00000, flags {in_nv,0,0,0,0}; else in_inf -> sign|0x7F800000, flags 0.
//   Both bypass rounding.
// - Zero significand with e<=0 -> signed zero, flags only NX if inexact.
// - Simultaneous accept and drain in the same cycle is legal; no bubble inserted.
// CONFIGURATION
// - FP_ROUND_SUBNORM_EN defined: subnormal results are rounded and packed as described above.
// - Not defined (flush-to-zero): any result whose final exponent is 0 with a nonzero significand
//   outputs signed zero with UF=NX=1. Normal, overflow and special paths are unchanged.
// TESTING
// - in_exp=127, shift=0, sig=27'h4000000, RNE -> 0x3F800000, flags 0, out_valid 2 cycles after accept.
// - in_exp=127, sig=27'h400000C, RNE -> 0x3F800002, NX. Same input RTZ -> 0x3F800001, NX.
// - in_exp=127, sig=27'h7FFFFFC, RNE -> 0x40000000 (mantissa carry), NX.
// - in_exp=254, shift=8'h01, sig=27'h4000000:
//   - RNE -> 0x7F800000, OF|NX.
//   - RTZ -> 0x7F7FFFFF, OF|NX.
//   - sign=1 with RUP -> 0xFF7FFFFF.
// - in_exp=0, shift=0, sig=27'h0000008:
//   - FP_ROUND_SUBNORM_EN defined -> 0x00000001, flags 0.
//   - Not defined -> 0x00000000, UF|NX.
// - Backpressure: out_ready=0 for 5 cycles while 4 beats are offered.
//   - in_ready drops after 2 accepts; out_result stays stable.
//   - After out_ready=1, all beats emerge in order with no loss or duplicates.
//   - reset_n pulse mid-stream clears out_valid immediately.

Source files
------------

// File: rtl/fp_round_pack.sv
// fp_round_pack: rounding and IEEE-754 binary32 packing stage that follows the
// FP add/sub normalizer. It is a two-register pipeline: S1 latches the adjusted
// exponent and the round-increment decision, and S2 latches the packed result
// and the fflags {NV, DZ, OF, UF, NX}.
// Build option: define FP_ROUND_SUBNORM_EN to round and pack subnormal results.
// When the macro is undefined, tiny nonzero results flush to signed zero with
// UF and NX set.
//
// Handshake: a beat moves across a port on a rising edge where valid && ready.
// A producer keeps valid and its data stable until that edge. out_valid stays
// high with out_result/out_flags frozen until out_ready is seen. in_ready is
// derived only from pipeline occupancy and out_ready, never from in_valid.
module fp_round_pack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [EXP_W-1:0]        in_shift,
    input  logic [FRAC_W+3:0]       in_sig,
    input  logic                    in_nan,
    input  logic                    in_inf,
    input  logic                    in_nv,
    input  logic [2:0]              in_rm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic [4:0]              out_flags
);

    localparam int MAN_W = FRAC_W + 1;   // hidden bit + stored fraction
    localparam int E_W   = EXP_W + 2;    // room for sign and overflow of the adjust

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    // ---------------- S1 decode ----------------
    rm_e              rm_n;
    logic [E_W-1:0]   e_d;
    logic             lsb, g, st, inexact_d, inc_d;

    assign rm_n      = (in_rm > 3'd4) ? RM_RNE : rm_e'(in_rm);
    assign e_d       = {2'b00, in_exp} + {{2{in_shift[EXP_W-1]}}, in_shift};
    assign lsb       = in_sig[3];
    assign g         = in_sig[2];
    assign st        = in_sig[1] | in_sig[0];
    assign inexact_d = g | st;

    // Round-increment decision for the selected rounding mode
    always_comb begin
        inc_d = 1'b0;
        case (rm_n)
            RM_RNE:  inc_d = g & (st | lsb);
            RM_RTZ:  inc_d = 1'b0;
            RM_RDN:  inc_d = inexact_d & in_sign;
            RM_RUP:  inc_d = inexact_d & ~in_sign;
            RM_RMM:  inc_d = g;
            default: inc_d = g & (st | lsb);
        endcase
    end

    // ---------------- flow control ----------------
    logic s1_valid;
    logic s2_ready, s1_load;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign s1_load  = in_valid && in_ready;

    // ---------------- S1 registers ----------------
    logic             s1_sign, s1_inc, s1_inexact, s1_nan, s1_inf, s1_nv;
    logic [E_W-1:0]   s1_e;
    logic [MAN_W-1:0] s1_man;
    rm_e              s1_rm;

    // S1 register: capture decoded beat on accept, empty when it moves to S2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_inc     <= 1'b0;
            s1_inexact <= 1'b0;
            s1_nan     <= 1'b0;
            s1_inf     <= 1'b0;
            s1_nv      <= 1'b0;
            s1_e       <= '0;
            s1_man     <= '0;
            s1_rm      <= RM_RNE;
        end else if (s1_load) begin
            s1_valid   <= 1'b1;
            s1_sign    <= in_sign;
            s1_inc     <= inc_d;
            s1_inexact <= inexact_d;
            s1_nan     <= in_nan;
            s1_inf     <= in_inf;
            s1_nv      <= in_nv;
            s1_e       <= e_d;
            s1_man     <= in_sig[FRAC_W+3:3];
            s1_rm      <= rm_n;
        end else if (s2_ready) begin
            s1_valid   <= 1'b0;
        end
    end

    // ---------------- S2 round and pack ----------------
    logic [MAN_W:0]          m;
    logic [E_W-1:0]          exp_f;
    logic [FRAC_W-1:0]       frac_f;
    logic                    ovf, tiny, to_inf, zero_sig;
    logic [EXP_W+FRAC_W:0]   res_d;
    logic [4:0]              flg_d;

    // Apply the increment, fix up the exponent, then select the packed result
    always_comb begin
        m      = {1'b0, s1_man} + {{MAN_W{1'b0}}, s1_inc};
        exp_f  = s1_e;
        frac_f = m[FRAC_W-1:0];
        if (m[MAN_W]) begin
            // carry out of the significand: 1.111.. rounded to 10.000..
            exp_f  = s1_e + E_W'(1);
            frac_f = '0;
        end else if (s1_e == '0 && m[MAN_W-1]) begin
            // largest subnormal rounded up into the smallest normal
            exp_f = E_W'(1);
        end
        ovf      = !exp_f[E_W-1] && (exp_f >= {2'b00, EXP_ONES});
        tiny     = exp_f[E_W-1] || (exp_f == '0);
        zero_sig = (m == '0) && (s1_e[E_W-1] || s1_e == '0);
        to_inf   = (s1_rm == RM_RNE) || (s1_rm == RM_RMM) ||
                   (s1_rm == RM_RUP && !s1_sign) || (s1_rm == RM_RDN && s1_sign);

        res_d = {s1_sign, exp_f[EXP_W-1:0], frac_f};
        flg_d = {s1_nv, 3'b000, s1_inexact};
        if (s1_nan) begin
            res_d = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};
            flg_d = {s1_nv, 4'b0000};
        end else if (s1_inf) begin
            res_d = {s1_sign, EXP_ONES, {FRAC_W{1'b0}}};
            flg_d = 5'b00000;
        end else if (zero_sig) begin
            res_d = {s1_sign, {(EXP_W+FRAC_W){1'b0}}};
            flg_d = {s1_nv, 3'b000, s1_inexact};
        end else if (ovf) begin
            res_d = to_inf ? {s1_sign, EXP_ONES, {FRAC_W{1'b0}}}
                           : {s1_sign, EXP_MAXF, {FRAC_W{1'b1}}};
            flg_d = {s1_nv, 1'b0, 1'b1, 1'b0, 1'b1};
        end else if (tiny) begin
`ifdef FP_ROUND_SUBNORM_EN
            res_d = {s1_sign, {EXP_W{1'b0}}, frac_f};
            flg_d = {s1_nv, 2'b00, s1_inexact, s1_inexact};
`else
            // flush-to-zero: any tiny nonzero result becomes signed zero
            res_d = {s1_sign, {(EXP_W+FRAC_W){1'b0}}};
            flg_d = {s1_nv, 2'b00, 1'b1, 1'b1};
`endif
        end
    end

    // S2 register: load a new result whenever the output is empty or draining
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res_d;
                out_flags  <= flg_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// tb_fp_round_pack: directed-vector bench for fp_round_pack. Expected results
// are hand-computed binary32 encodings. Build with FP_ROUND_SUBNORM_EN defined
// or not; the subnormal expectations follow the same macro.
module tb_fp_round_pack;

    localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [7:0]  in_shift = '0;
    logic [26:0] in_sig = '0;
    logic        in_nan = 1'b0, in_inf = 1'b0, in_nv = 1'b0;
    logic [2:0]  in_rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_flags;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        sign;
        logic [7:0]  e;
        logic [7:0]  sh;
        logic [26:0] sig;
        logic [2:0]  rm;
        logic        nan;
        logic        inf;
        logic        nv;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    fp_round_pack dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_shift(in_shift), .in_sig(in_sig),
        .in_nan(in_nan), .in_inf(in_inf), .in_nv(in_nv), .in_rm(in_rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    // clock
    always #5 clk = ~clk;

    // safety net in case a handshake never completes
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // driver: present one beat, then wait (bounded) for its result
    task automatic apply_vec(input vec_t v, output logic [31:0] res, output logic [4:0] flg, output int lat);
        in_sign = v.sign; in_exp = v.e; in_shift = v.sh; in_sig = v.sig; in_rm = v.rm;
        in_nan = v.nan; in_inf = v.inf; in_nv = v.nv;
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_result;
        flg = out_flags;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_result !== 32'h0) $display("FAIL reset_result got %h want 00000000", out_result); else n_pass++;
        n_total++; if (out_flags !== 5'h0) $display("FAIL reset_flags got %h want 00", out_flags); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_post_valid got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_rounding();
        vec_t tv[11];
        logic [31:0] r;
        logic [4:0]  f;
        int lat;
        tv[0]  = '{1'b0, 8'd127, 8'h00, 27'h4000000, RNE,    1'b0, 1'b0, 1'b0, 32'h3F800000, 5'h00};
        tv[1]  = '{1'b0, 8'd127, 8'h00, 27'h400000C, RNE,    1'b0, 1'b0, 1'b0, 32'h3F800002, 5'h01};
        tv[2]  = '{1'b0, 8'd127, 8'h00, 27'h400000C, RTZ,    1'b0, 1'b0, 1'b0, 32'h3F800001, 5'h01};
        tv[3]  = '{1'b0, 8'd127, 8'h00, 27'h7FFFFFC, RNE,    1'b0, 1'b0, 1'b0, 32'h40000000, 5'h01};
        tv[4]  = '{1'b1, 8'd127, 8'h00, 27'h400000C, RDN,    1'b0, 1'b0, 1'b0, 32'hBF800002, 5'h01};
        tv[5]  = '{1'b0, 8'd127, 8'h00, 27'h400000C, RUP,    1'b0, 1'b0, 1'b0, 32'h3F800002, 5'h01};
        tv[6]  = '{1'b1, 8'd127, 8'h00, 27'h400000C, RUP,    1'b0, 1'b0, 1'b0, 32'hBF800001, 5'h01};
        tv[7]  = '{1'b0, 8'd127, 8'h00, 27'h4000004, RNE,    1'b0, 1'b0, 1'b0, 32'h3F800000, 5'h01};
        tv[8]  = '{1'b0, 8'd127, 8'h00, 27'h4000004, RMM,    1'b0, 1'b0, 1'b0, 32'h3F800001, 5'h01};
        tv[9]  = '{1'b0, 8'd130, 8'hFE, 27'h4000000, RNE,    1'b0, 1'b0, 1'b0, 32'h40000000, 5'h00};
        tv[10] = '{1'b0, 8'd127, 8'h00, 27'h400000C, 3'b111, 1'b0, 1'b0, 1'b0, 32'h3F800002, 5'h01};
        foreach (tv[i]) begin
            apply_vec(tv[i], r, f, lat);
            n_total++; if (lat != 2) $display("FAIL round[%0d]_latency got %0d want 2", i, lat); else n_pass++;
            n_total++; if (r !== tv[i].res) $display("FAIL round[%0d]_result got %h want %h", i, r, tv[i].res); else n_pass++;
            n_total++; if (f !== tv[i].flg) $display("FAIL round[%0d]_flags got %h want %h", i, f, tv[i].flg); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        vec_t tv[5];
        logic [31:0] r;
        logic [4:0]  f;
        int lat;
        tv[0] = '{1'b0, 8'd254, 8'h01, 27'h4000000, RNE, 1'b0, 1'b0, 1'b0, 32'h7F800000, 5'h05};
        tv[1] = '{1'b0, 8'd254, 8'h01, 27'h4000000, RTZ, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF, 5'h05};
        tv[2] = '{1'b1, 8'd254, 8'h01, 27'h4000000, RUP, 1'b0, 1'b0, 1'b0, 32'hFF7FFFFF, 5'h05};
        tv[3] = '{1'b1, 8'd254, 8'h01, 27'h4000000, RDN, 1'b0, 1'b0, 1'b0, 32'hFF800000, 5'h05};
        tv[4] = '{1'b0, 8'd254, 8'h00, 27'h7FFFFFC, RNE, 1'b0, 1'b0, 1'b0, 32'h7F800000, 5'h05};
        foreach (tv[i]) begin
            apply_vec(tv[i], r, f, lat);
            n_total++; if (r !== tv[i].res) $display("FAIL ovf[%0d]_result got %h want %h", i, r, tv[i].res); else n_pass++;
            n_total++; if (f !== tv[i].flg) $display("FAIL ovf[%0d]_flags got %h want %h", i, f, tv[i].flg); else n_pass++;
        end
    endtask

    task automatic test_subnormal();
        vec_t tv[4];
        logic [31:0] r;
        logic [4:0]  f;
        int lat;
`ifdef FP_ROUND_SUBNORM_EN
        tv[0] = '{1'b0, 8'd0, 8'h00, 27'h0000008, RNE, 1'b0, 1'b0, 1'b0, 32'h00000001, 5'h00};
        tv[1] = '{1'b0, 8'd0, 8'h00, 27'h000000C, RNE, 1'b0, 1'b0, 1'b0, 32'h00000002, 5'h03};
`else
        tv[0] = '{1'b0, 8'd0, 8'h00, 27'h0000008, RNE, 1'b0, 1'b0, 1'b0, 32'h00000000, 5'h03};
        tv[1] = '{1'b0, 8'd0, 8'h00, 27'h000000C, RNE, 1'b0, 1'b0, 1'b0, 32'h00000000, 5'h03};
`endif
        tv[2] = '{1'b0, 8'd0, 8'h00, 27'h3FFFFFC, RNE, 1'b0, 1'b0, 1'b0, 32'h00800000, 5'h01};
        tv[3] = '{1'b1, 8'd0, 8'h00, 27'h0000002, RNE, 1'b0, 1'b0, 1'b0, 32'h80000000, 5'h01};
        foreach (tv[i]) begin
            apply_vec(tv[i], r, f, lat);
            n_total++; if (r !== tv[i].res) $display("FAIL subn[%0d]_result got %h want %h", i, r, tv[i].res); else n_pass++;
            n_total++; if (f !== tv[i].flg) $display("FAIL subn[%0d]_flags got %h want %h", i, f, tv[i].flg); else n_pass++;
        end
    endtask

    task automatic test_specials();
        vec_t tv[3];
        logic [31:0] r;
        logic [4:0]  f;
        int lat;
        tv[0] = '{1'b1, 8'd127, 8'h00, 27'h400000C, RNE, 1'b1, 1'b0, 1'b1, 32'h7FC00000, 5'h10};
        tv[1] = '{1'b1, 8'd127, 8'h00, 27'h400000C, RUP, 1'b0, 1'b1, 1'b0, 32'hFF800000, 5'h00};
        tv[2] = '{1'b0, 8'd254, 8'h01, 27'h400000C, RNE, 1'b1, 1'b1, 1'b0, 32'h7FC00000, 5'h00};
        foreach (tv[i]) begin
            apply_vec(tv[i], r, f, lat);
            n_total++; if (r !== tv[i].res) $display("FAIL spec[%0d]_result got %h want %h", i, r, tv[i].res); else n_pass++;
            n_total++; if (f !== tv[i].flg) $display("FAIL spec[%0d]_flags got %h want %h", i, f, tv[i].flg); else n_pass++;
        end
        in_nan = 1'b0; in_inf = 1'b0; in_nv = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic        want_v;
        logic [31:0] want;
        exp_q.delete();
        out_ready = 1'b1;
        in_shift = 8'h00; in_sig = 27'h400000C; in_rm = RTZ;
        #1;
        for (int j = 0; j < 6; j++) begin
            if (j < 4) begin
                in_valid = 1'b1;
                in_sign  = j[0];
                in_exp   = 8'(100 + j);
                n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d] got %b want 1", j, in_ready); else n_pass++;
                exp_q.push_back({j[0], 8'(100 + j), 23'd1});
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            want_v = (j >= 1 && j <= 4);
            n_total++; if (out_valid !== want_v) $display("FAIL b2b_valid[%0d] got %b want %b", j, out_valid, want_v); else n_pass++;
            if (out_valid === 1'b1 && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                n_total++; if (out_result !== want) $display("FAIL b2b_result[%0d] got %h want %h", j, out_result, want); else n_pass++;
                n_total++; if (out_flags !== 5'h01) $display("FAIL b2b_flags[%0d] got %h want 01", j, out_flags); else n_pass++;
            end
        end
        n_total++; if (exp_q.size() != 0) $display("FAIL b2b_missing got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int got = 0;
        bit drop_checked = 0;
        exp_q.delete();
        in_sign = 1'b0; in_shift = 8'h00; in_sig = 27'h4000000; in_rm = RNE;
        fork
            begin : drv
                int cyc = 0;
                bit take;
                while (acc < 4 && cyc < 40) begin
                    out_ready = (cyc >= 5);
                    in_valid  = 1'b1;
                    in_exp    = 8'(127 + acc);
                    #1;
                    if (acc == 2 && !out_ready && !drop_checked) begin
                        drop_checked = 1;
                        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_drop got %b want 0", in_ready); else n_pass++;
                    end
                    take = (in_ready === 1'b1);
                    if (take) exp_q.push_back(32'h3F800000 + (32'(acc) << 23));
                    @(posedge clk); #1;
                    if (take) acc++;
                    cyc++;
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            begin : mon
                int hc = 0;
                bit prev_stall = 0;
                logic [31:0] held = '0;
                logic [31:0] want;
                while (got < 4 && hc < 60) begin
                    @(negedge clk);
                    hc++;
                    if (prev_stall) begin
                        n_total++; if (out_result !== held) $display("FAIL bp_stable got %h want %h", out_result, held); else n_pass++;
                    end
                    if (out_valid === 1'b1 && out_ready === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            n_total++; $display("FAIL bp_extra_beat got %h want none", out_result);
                        end else begin
                            want = exp_q.pop_front();
                            n_total++; if (out_result !== want) $display("FAIL bp_order[%0d] got %h want %h", got, out_result, want); else n_pass++;
                        end
                        got++;
                    end
                    prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
                    held = out_result;
                end
                n_total++; if (got != 4) $display("FAIL bp_count got %0d want 4", got); else n_pass++;
            end
        join
        @(posedge clk); #1;
        repeat (2) begin @(posedge clk); #1; end
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_duplicate got valid %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_sign = 1'b0; in_shift = 8'h00; in_sig = 27'h4000000; in_rm = RNE;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_exp   = 8'(127 + k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got %b want 1", out_valid); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_result !== 32'h0) $display("FAIL mid_rst_result got %h want 00000000", out_result); else n_pass++;
        @(negedge clk) reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got %b want 1", in_ready); else n_pass++;
        repeat (3) begin @(posedge clk); #1; end
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_discard got valid %b want 0", out_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_overflow();
        test_subnormal();
        test_specials();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
